// File: rtl/powlib_ipmaxi_resp.sv
// AXI write-response stage: throttles AW at MAX_OUT bursts, terminates B, captures errors (comb AW gating, status 1 cycle late).
// Optional POWLIB_IPMAXI_RESP_ERRADDR_EN keeps an address FIFO so erraddr names the failing burst; otherwise erraddr is 0.
module powlib_ipmaxi_resp #(
  parameter int B_AW    = 32,
  parameter int MAX_OUT = 8,
  parameter int ERRW    = 16,
  localparam int OUTW   = $clog2(MAX_OUT) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] awaddr,
  input  logic            awvalid_m,
  output logic            awready_m,
  output logic            awvalid_s,
  input  logic            awready_s,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  input  logic            errclr,
  output logic [OUTW-1:0] outcnt,
  output logic            idle,
  output logic            err,
  output logic [1:0]      errresp,
  output logic [B_AW-1:0] erraddr,
  output logic [ERRW-1:0] errcnt,
  output logic            uerr
);

  logic            full, awh, bh, pop, unexp, is_err;
  logic [B_AW-1:0] head;

  logic            bready_q, bready_d;
  logic [OUTW-1:0] outcnt_q, outcnt_d;
  logic            err_q, err_d;
  logic [1:0]      errresp_q, errresp_d;
  logic [ERRW-1:0] errcnt_q, errcnt_d;
  logic            uerr_q, uerr_d;

  always_comb begin
    full      = (outcnt_q == OUTW'(MAX_OUT));
    awvalid_s = awvalid_m & ~full;
    awready_m = awready_s & ~full;
    awh       = awvalid_m & awready_s & ~full;
    bh        = bvalid & bready_q;
    pop       = bh & (outcnt_q != '0);
    unexp     = bh & (outcnt_q == '0);
    is_err    = pop & (bresp != 2'b00);
  end

`ifdef POWLIB_IPMAXI_RESP_ERRADDR_EN
  localparam int PW = $clog2(MAX_OUT);

  logic [B_AW-1:0] mem_q [MAX_OUT];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [B_AW-1:0] erraddr_q, erraddr_d;

  // Storage needs no reset: the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (awh) mem_q[wptr_q] <= awaddr;
  end

  always_comb begin
    head      = mem_q[rptr_q];
    wptr_d    = awh ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
    erraddr_d = erraddr_q;
    if (errclr) erraddr_d = '0;
    if (is_err && (!err_q || errclr)) erraddr_d = head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      erraddr_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      erraddr_q <= erraddr_d;
    end
  end

  assign erraddr = erraddr_q;
`else
  logic unused_awaddr;

  assign unused_awaddr = ^awaddr;
  assign head          = '0;
  assign erraddr       = '0;
`endif

  always_comb begin
    bready_d  = 1'b1;
    outcnt_d  = outcnt_q + OUTW'(awh) - OUTW'(pop);
    err_d     = err_q;
    errresp_d = errresp_q;
    errcnt_d  = errcnt_q;
    uerr_d    = uerr_q;
    if (errclr) begin
      err_d     = 1'b0;
      errresp_d = 2'b00;
      errcnt_d  = '0;
      uerr_d    = 1'b0;
    end
    if (unexp) uerr_d = 1'b1;
    // Applied after the clear so a coincident error is captured fresh.
    if (is_err) begin
      if (errcnt_d != '1) errcnt_d = errcnt_d + ERRW'(1);
      if (!err_d) begin
        err_d     = 1'b1;
        errresp_d = bresp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bready_q  <= 1'b0;
      outcnt_q  <= '0;
      err_q     <= 1'b0;
      errresp_q <= 2'b00;
      errcnt_q  <= '0;
      uerr_q    <= 1'b0;
    end else begin
      bready_q  <= bready_d;
      outcnt_q  <= outcnt_d;
      err_q     <= err_d;
      errresp_q <= errresp_d;
      errcnt_q  <= errcnt_d;
      uerr_q    <= uerr_d;
    end
  end

  assign bready  = bready_q;
  assign outcnt  = outcnt_q;
  assign idle    = (outcnt_q == '0);
  assign err     = err_q;
  assign errresp = errresp_q;
  assign errcnt  = errcnt_q;
  assign uerr    = uerr_q;

endmodule

// File: tb/tb_powlib_ipmaxi_resp.sv
// Directed bench for powlib_ipmaxi_resp (MAX_OUT=8); erraddr expectations follow POWLIB_IPMAXI_RESP_ERRADDR_EN.
module tb_powlib_ipmaxi_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid_m, awready_m, awvalid_s, awready_s;
  logic [1:0]  bresp;
  logic        bvalid, bready, errclr;
  logic [3:0]  outcnt;
  logic        idle, err, uerr;
  logic [1:0]  errresp;
  logic [31:0] erraddr;
  logic [15:0] errcnt;

  int n_cmp = 0;
  int n_bad = 0;

  powlib_ipmaxi_resp #(.B_AW(32), .MAX_OUT(8), .ERRW(16)) dut (
    .clk(clk), .rst(rst), .awaddr(awaddr), .awvalid_m(awvalid_m),
    .awready_m(awready_m), .awvalid_s(awvalid_s), .awready_s(awready_s),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .errclr(errclr),
    .outcnt(outcnt), .idle(idle), .err(err), .errresp(errresp),
    .erraddr(erraddr), .errcnt(errcnt), .uerr(uerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ea(input logic [31:0] a);
`ifdef POWLIB_IPMAXI_RESP_ERRADDR_EN
    return a;
`else
    return 32'h0 & a;
`endif
  endfunction

  // Inputs change 1ns after each rising edge; checks happen at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [31:0] a);
    awaddr = a; awvalid_m = 1'b1; awready_s = 1'b1;
    tick();
    awvalid_m = 1'b0; awready_s = 1'b0;
  endtask

  task automatic b(input logic [1:0] r);
    bvalid = 1'b1; bresp = r;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  initial begin
    rst = 1'b0; awaddr = '0; awvalid_m = 1'b0; awready_s = 1'b0;
    bresp = 2'b00; bvalid = 1'b0; errclr = 1'b0;
    #3;
    chk("rst_outcnt", outcnt, 0);
    chk("rst_idle", idle, 1);
    chk("rst_bready", bready, 0);
    chk("rst_err", err, 0);
    chk("rst_errcnt", errcnt, 0);
    chk("rst_uerr", uerr, 0);
    #9 rst = 1'b1;
    chk("rel_bready_pre", bready, 0);
    tick();
    chk("rel_bready", bready, 1);

    // Basic flow
    aw(32'h100); chk("basic_cnt1", outcnt, 1);
    aw(32'h200); chk("basic_cnt2", outcnt, 2);
    aw(32'h300); chk("basic_cnt3", outcnt, 3);
    chk("basic_busy", idle, 0);
    b(2'b00); chk("basic_cnt_d2", outcnt, 2);
    b(2'b00); chk("basic_cnt_d1", outcnt, 1);
    b(2'b00); chk("basic_cnt_d0", outcnt, 0);
    chk("basic_idle", idle, 1);
    chk("basic_err", err, 0);
    chk("basic_errcnt", errcnt, 0);

    // Throttle
    for (int i = 0; i < 8; i++) aw(32'h1000 + 32'(i));
    chk("thr_cnt8", outcnt, 8);
    awaddr = 32'h9999; awvalid_m = 1'b1; awready_s = 1'b1;
    #1;
    chk("thr_awvalid_s", awvalid_s, 0);
    chk("thr_awready_m", awready_m, 0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("thr_cnt7", outcnt, 7);
    chk("thr_awvalid_s_open", awvalid_s, 1);
    chk("thr_awready_m_open", awready_m, 1);
    tick();
    awvalid_m = 1'b0; awready_s = 1'b0;
    chk("thr_cnt8b", outcnt, 8);
    for (int i = 0; i < 8; i++) b(2'b00);
    chk("thr_drain", outcnt, 0);
    chk("thr_err", err, 0);

    // Error capture
    aw(32'h1000); aw(32'h2000); aw(32'h3000);
    b(2'b00); chk("ec_ok_err", err, 0);
    b(2'b10); b(2'b11);
    chk("ec_err", err, 1);
    chk("ec_errresp", errresp, 2);
    chk("ec_erraddr", erraddr, ea(32'h2000));
    chk("ec_errcnt", errcnt, 2);
    chk("ec_outcnt", outcnt, 0);

    // Simultaneous AW and B at outcnt=4
    aw(32'h10); aw(32'h20); aw(32'h30); aw(32'h40);
    chk("sim_cnt4", outcnt, 4);
    awaddr = 32'h50; awvalid_m = 1'b1; awready_s = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    tick();
    awvalid_m = 1'b0; awready_s = 1'b0; bvalid = 1'b0;
    chk("sim_cnt_hold", outcnt, 4);
    // errclr with DECERR: head must now be 0x20
    errclr = 1'b1; bvalid = 1'b1; bresp = 2'b11;
    tick();
    errclr = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    chk("clr_err", err, 1);
    chk("clr_errcnt", errcnt, 1);
    chk("clr_errresp", errresp, 3);
    chk("clr_erraddr", erraddr, ea(32'h20));
    chk("clr_cnt", outcnt, 3);
    b(2'b10);
    chk("sticky_errcnt", errcnt, 2);
    chk("sticky_errresp", errresp, 3);
    chk("sticky_erraddr", erraddr, ea(32'h20));
    errclr = 1'b1; tick(); errclr = 1'b0;
    chk("clr_only_err", err, 0);
    chk("clr_only_errcnt", errcnt, 0);
    chk("clr_only_errresp", errresp, 0);
    chk("clr_only_erraddr", erraddr, 0);
    b(2'b00); b(2'b00);
    chk("sim_drain", outcnt, 0);

    // Unexpected response
    b(2'b10);
    chk("unexp_uerr", uerr, 1);
    chk("unexp_cnt", outcnt, 0);
    chk("unexp_errcnt", errcnt, 0);
    chk("unexp_err", err, 0);
    errclr = 1'b1; tick(); errclr = 1'b0;
    chk("unexp_clr", uerr, 0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) aw(32'h400 + 32'(i));
    b(2'b10);
    aw(32'h500);
    chk("mr_cnt5", outcnt, 5);
    chk("mr_err_pre", err, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_outcnt", outcnt, 0);
    chk("mr_idle", idle, 1);
    chk("mr_bready", bready, 0);
    chk("mr_err", err, 0);
    chk("mr_errcnt", errcnt, 0);
    chk("mr_errresp", errresp, 0);
    chk("mr_erraddr", erraddr, 0);
    #1 rst = 1'b1;
    chk("mr_bready_rel", bready, 0);
    tick();
    chk("mr_bready_on", bready, 1);
    b(2'b00);
    chk("mr_late_uerr", uerr, 1);
    chk("mr_late_cnt", outcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
